// File: rtl/updown_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : updown_button_ctrl
// Description : Button front-end for the BCD up/down counter. Synchronises
//               and debounces a direction button and a step button, toggles
//               the direction select on each dir press and emits one-cycle
//               count-enable pulses on each step press.
//
//   Ports:
//     clk           in   rising-edge clock
//     rst_n         in   synchronous reset, active-low
//     btn_dir_raw   in   raw bouncy direction button (1 = pressed)
//     btn_step_raw  in   raw bouncy step button (1 = pressed)
//     sel           out  direction to counter (1 = up, 0 = down)
//     step          out  one-cycle count-enable pulse
//     dir_changed   out  one-cycle pulse, coincident with sel's new value
//     btn_step_db   out  debounced step-button level
//
//   Build option:
//     AUTO_REPEAT_EN  when defined, a held step button auto-repeats after
//                     REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
//
// Revision    : 1.0  initial release
// ============================================================================
module updown_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_dir_raw,
    input  logic btn_step_raw,
    output logic sel,
    output logic step,
    output logic dir_changed,
    output logic btn_step_db
);

    localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

    // Illegal overrides leave this marker block in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    end

    logic [1:0] w_raw;      // [0] = dir, [1] = step
    logic [1:0] w_db;
    logic       w_dir_db;
    logic       w_step_db;
    logic       w_dir_rise;
    logic       w_step_rise;
    logic       w_step_req;
    logic       w_fire;
    logic       w_defer;

    logic       r_dir_db_d;
    logic       r_step_db_d;
    logic       r_step_pend;

    assign w_raw = {btn_step_raw, btn_dir_raw};

    // ------------------------------------------------------------------------
    // Per-button 2-flop synchroniser + debounce. A new level is accepted only
    // after DEBOUNCE_CYCLES consecutive cycles of disagreement with the
    // current stable level; any agreement restarts the count.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_debounce
        logic              r_sync1;
        logic              r_sync2;
        logic              r_stable;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_db[g] = r_stable;
    end

    assign w_dir_db    = w_db[0];
    assign w_step_db   = w_db[1];
    assign btn_step_db = w_step_db;

    assign w_dir_rise  = w_dir_db  & ~r_dir_db_d;
    assign w_step_rise = w_step_db & ~r_step_db_d;

    // A step request (fresh or previously deferred) that collides with a
    // direction change is held one cycle so the counter steps in the new
    // direction. Dropping the button cancels anything still pending.
    assign w_fire  = (w_step_req | r_step_pend) & ~w_dir_rise & w_step_db;
    assign w_defer = (w_step_req | r_step_pend) &  w_dir_rise & w_step_db;

`ifdef AUTO_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RP_W    = $clog2(c_REP_MAX + 1);
    localparam logic [c_RP_W-1:0] c_RP_DELAY = c_RP_W'(REPEAT_DELAY);
    localparam logic [c_RP_W-1:0] c_RP_RATE  = c_RP_W'(REPEAT_RATE);

    logic              r_rep_active;   // at least one pulse issued this press
    logic              r_rep_first;    // next repeat uses the initial delay
    logic [c_RP_W-1:0] r_rep_cnt;      // cycles since last issued pulse
    logic [c_RP_W-1:0] w_rep_target;
    logic              w_rep_due;

    assign w_rep_target = r_rep_first ? c_RP_DELAY : c_RP_RATE;
    assign w_rep_due    = r_rep_active & (r_rep_cnt == w_rep_target);
    assign w_step_req   = w_step_rise | w_rep_due;

    // The counter restarts from each pulse actually issued, so a deferred
    // pulse shifts all later repeats. It holds at the target while deferred.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rep_active <= 1'b0;
            r_rep_first  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (!w_step_db) begin
            r_rep_active <= 1'b0;
            r_rep_first  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_fire) begin
            r_rep_active <= 1'b1;
            r_rep_first  <= ~r_rep_active;
            r_rep_cnt    <= c_RP_W'(1);
        end else if (r_rep_active && (r_rep_cnt != w_rep_target)) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_step_req = w_step_rise;
`endif

    // ------------------------------------------------------------------------
    // Registered edge detect and output generation.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel         <= 1'b1;
            step        <= 1'b0;
            dir_changed <= 1'b0;
            r_dir_db_d  <= 1'b0;
            r_step_db_d <= 1'b0;
            r_step_pend <= 1'b0;
        end else begin
            r_dir_db_d  <= w_dir_db;
            r_step_db_d <= w_step_db;
            dir_changed <= w_dir_rise;
            if (w_dir_rise) begin
                sel <= ~sel;
            end
            step        <= w_fire;
            r_step_pend <= w_defer;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_updown_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_button_ctrl
// Description : Directed self-checking bench for updown_button_ctrl with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=64, REPEAT_RATE=16.
// Revision    : 1.0  initial release
// ============================================================================
module tb_updown_button_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_dir_raw;
    logic btn_step_raw;
    logic sel;
    logic step;
    logic dir_changed;
    logic btn_step_db;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_step = 0;   // step pulses seen
    int n_dc   = 0;   // dir_changed pulses seen
    int n_both = 0;   // cycles with step and dir_changed together

    updown_button_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (64),
        .REPEAT_RATE     (16)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_dir_raw  (btn_dir_raw),
        .btn_step_raw (btn_step_raw),
        .sel          (sel),
        .step         (step),
        .dir_changed  (dir_changed),
        .btn_step_db  (btn_step_db)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later and tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (step === 1'b1)        n_step++;
        if (dir_changed === 1'b1) n_dc++;
        if (step === 1'b1 && dir_changed === 1'b1) n_both++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic bit rep_expect(input int i);
`ifdef AUTO_REPEAT_EN
        return (i == 7) || (i >= 71 && ((i - 71) % 16) == 0);
`else
        return (i == 7);
`endif
    endfunction

    initial begin
        int base;
        int bad;
        bit exp_step;

        // ---------------- 1: reset with both buttons held ----------------
        rst_n        = 1'b0;
        btn_dir_raw  = 1'b1;
        btn_step_raw = 1'b1;
        tick();
        chk("reset_e1 {sel,step,dc,db}", {28'd0, sel, step, dir_changed, btn_step_db}, 32'b1000);
        tick();
        chk("reset_e2 {sel,step,dc,db}", {28'd0, sel, step, dir_changed, btn_step_db}, 32'b1000);
        btn_dir_raw  = 1'b0;
        btn_step_raw = 1'b0;
        tick();
        rst_n = 1'b1;
        n_step = 0;
        n_dc   = 0;
        idle(10);
        chk("idle_steps", n_step, 0);
        chk("idle_sel", sel, 1);

        // ---------------- 2: bouncing step button ----------------
        for (int i = 0; i < 12; i++) begin
            btn_step_raw = ((i / 2) % 2 == 0);
            tick();
        end
        chk("bounce_db_low", btn_step_db, 0);
        btn_step_raw = 1'b1;
        idle(5);
        chk("bounce_db_e5", btn_step_db, 0);
        tick();
        chk("bounce_db_e6", btn_step_db, 1);
        chk("bounce_step_e6", step, 0);
        tick();
        chk("bounce_step_e7", step, 1);
        tick();
        chk("bounce_step_e8", step, 0);
        idle(20);
        chk("bounce_nsteps", n_step, 1);
        btn_step_raw = 1'b0;
        idle(12);
        chk("bounce_db_release", btn_step_db, 0);

        // ---------------- 3: direction toggling ----------------
        n_dc   = 0;
        n_step = 0;
        btn_dir_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("dir1_t%0d {sel,dc}", i), {30'd0, sel, dir_changed},
                {30'd0, (i >= 7) ? 1'b0 : 1'b1, (i == 7) ? 1'b1 : 1'b0});
        end
        btn_dir_raw = 1'b0;
        idle(12);
        chk("dir_release_sel", sel, 0);
        chk("dir_release_dc", n_dc, 1);
        btn_dir_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("dir2_t%0d {sel,dc}", i), {30'd0, sel, dir_changed},
                {30'd0, (i >= 7) ? 1'b1 : 1'b0, (i == 7) ? 1'b1 : 1'b0});
        end
        btn_dir_raw = 1'b0;
        idle(12);
        chk("dir_total_dc", n_dc, 2);
        chk("dir_no_step", n_step, 0);

        // ---------------- 4: simultaneous press ----------------
        btn_dir_raw  = 1'b1;
        btn_step_raw = 1'b1;
        idle(6);
        chk("sim_t6 {sel,step,dc}", {29'd0, sel, step, dir_changed}, 32'b100);
        tick();
        chk("sim_T {sel,step,dc}", {29'd0, sel, step, dir_changed}, 32'b001);
        tick();
        chk("sim_T1 {sel,step,dc}", {29'd0, sel, step, dir_changed}, 32'b010);
        tick();
        chk("sim_T2 {sel,step,dc}", {29'd0, sel, step, dir_changed}, 32'b000);
        btn_dir_raw  = 1'b0;
        btn_step_raw = 1'b0;
        idle(12);

        // ---------------- 5: held step button (auto-repeat) ----------------
        n_step = 0;
        bad    = 0;
        btn_step_raw = 1'b1;
        for (int i = 1; i <= 206; i++) begin
            tick();
            exp_step = rep_expect(i);
            if (step !== exp_step) bad++;
        end
        chk("rep_db_held", btn_step_db, 1);
        chk("rep_pattern_bad_cycles", bad, 0);
`ifdef AUTO_REPEAT_EN
        chk("rep_count", n_step, 10);
`else
        chk("rep_count", n_step, 1);
`endif
        base = n_step;
        btn_step_raw = 1'b0;
        idle(40);
        chk("rep_after_release", n_step, base);

        // ---------------- 6: reset mid-debounce ----------------
        chk("pre6_sel", sel, 0);
        n_step = 0;
        btn_step_raw = 1'b1;
        idle(5);                // step debounce counter now 3
        rst_n = 1'b0;
        tick();
        chk("rst6_e1 {sel,step,dc,db}", {28'd0, sel, step, dir_changed, btn_step_db}, 32'b1000);
        tick();
        chk("rst6_e2 {sel,step,dc,db}", {28'd0, sel, step, dir_changed, btn_step_db}, 32'b1000);
        rst_n = 1'b1;
        idle(6);
        chk("rst6_db_e6", btn_step_db, 1);
        chk("rst6_nsteps_e6", n_step, 0);
        tick();
        chk("rst6_step_e7", step, 1);
        idle(3);
        chk("rst6_nsteps", n_step, 1);
        chk("rst6_sel", sel, 1);
        btn_step_raw = 1'b0;
        idle(12);

        chk("never_step_and_dc", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
